// File: rtl/project_2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : project_2_pkg
// Purpose  : Opcodes, function codes, instruction field positions, I/O
//            addresses and ALU/compare helpers for the 2-stage CPU.
// Revision : 1.0 - initial release
// ============================================================================
package project_2_pkg;

  // Opcodes (instruction bits [31:28])
  localparam logic [3:0] OP_ALU_R  = 4'h0;
  localparam logic [3:0] OP_ALU_I  = 4'h8;
  localparam logic [3:0] OP_CMP_R  = 4'h2;
  localparam logic [3:0] OP_CMP_I  = 4'hA;
  localparam logic [3:0] OP_LW     = 4'h9;
  localparam logic [3:0] OP_SW     = 4'h5;
  localparam logic [3:0] OP_BRANCH = 4'h6;
  localparam logic [3:0] OP_JAL    = 4'hB;

  // ALU function codes
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_AND  = 4'h4;
  localparam logic [3:0] FN_OR   = 4'h5;
  localparam logic [3:0] FN_XOR  = 4'h6;
  localparam logic [3:0] FN_NAND = 4'hC;
  localparam logic [3:0] FN_NOR  = 4'hD;
  localparam logic [3:0] FN_XNOR = 4'hE;

  // Compare function codes (shared by CMP-R, CMP-I and BRANCH)
  localparam logic [3:0] FN_F   = 4'h0;
  localparam logic [3:0] FN_EQ  = 4'h1;
  localparam logic [3:0] FN_LT  = 4'h2;
  localparam logic [3:0] FN_LTE = 4'h3;
  localparam logic [3:0] FN_T   = 4'h8;
  localparam logic [3:0] FN_NE  = 4'h9;
  localparam logic [3:0] FN_GTE = 4'hA;
  localparam logic [3:0] FN_GT  = 4'hB;

  // Instruction field LSB positions (each field is 4 bits wide)
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned FN_LSB  = 24;
  localparam int unsigned RD_LSB  = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_LSB = 12;

  // Memory-mapped I/O; the whole 0xF------- region is kept off the RAM
  localparam logic [3:0]  IO_REGION = 4'hF;
  localparam logic [31:0] IO_HEX    = 32'hF000_0000;
  localparam logic [31:0] IO_LEDR   = 32'hF000_0004;
  localparam logic [31:0] IO_LEDG   = 32'hF000_0008;
  localparam logic [31:0] IO_KEY    = 32'hF000_0010;
  localparam logic [31:0] IO_SW     = 32'hF000_0014;

  // Logic/arithmetic unit; unknown function codes yield zero
  function automatic logic [31:0] alu_op(input logic [3:0] fn,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (fn)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      FN_NAND: return ~(a & b);
      FN_NOR:  return ~(a | b);
      FN_XNOR: return ~(a ^ b);
      default: return 32'h0;
    endcase
  endfunction

  // Signed comparator; unknown function codes yield false
  function automatic logic cmp_op(input logic [3:0] fn,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    case (fn)
      FN_F:    return 1'b0;
      FN_EQ:   return a == b;
      FN_LT:   return $signed(a) <  $signed(b);
      FN_LTE:  return $signed(a) <= $signed(b);
      FN_T:    return 1'b1;
      FN_NE:   return a != b;
      FN_GTE:  return $signed(a) >= $signed(b);
      FN_GT:   return $signed(a) >  $signed(b);
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/project_2_seven_seg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_decoder
// Purpose  : Hex nibble to seven-segment pattern, active-low, seg = {g..a}.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup for 0-9, A, b, C, d, E, F
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/project_2.sv
`default_nettype none
// ============================================================================
// Module   : project_2
// Purpose  : 32-bit 2-stage pipelined CPU. Stage 1 fetches, decodes, reads
//            and forwards operands, computes and resolves the next PC.
//            Stage 2 does memory / I/O access and register writeback.
// Revision : 1.0 - initial release
// ============================================================================
module project_2
  import project_2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       CLOCK_50,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic [9:0] LEDR,
  output logic [7:0] LEDG,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  // ---------------- storage (never reset, so preloads survive) ----------
  logic [31:0] pcOut, pc_d, pc_plus4;
  logic [31:0] instWord;
  logic [31:0] buff_aluOut, buff_sr2Out, buff_instWord;
  logic        buff_memWrite, buff_memtoReg, buff_regWrite, buff_jal;
  logic [3:0]  buff_KEY;
  logic [9:0]  buff_SW;
  logic [3:0]  buff_rd;
  logic [31:0] memDataOut, load_data, dataMuxOut;
  logic        is_io, ram_we;

  if (1'b1) begin : instMemory
    logic [31:0] data [256];
  end

  if (1'b1) begin : dataMemory
    logic [31:0] data [2048];
    // Stage-2 store into RAM
    always_ff @(posedge clk) begin
      if (ram_we) data[buff_aluOut[12:2]] <= buff_sr2Out;
    end
  end

  if (1'b1) begin : dprf
    logic [31:0] regs [16];
    // Stage-2 register writeback
    always_ff @(posedge clk) begin
      if (buff_regWrite) regs[buff_rd] <= dataMuxOut;
    end
  end

  // ---------------- stage 1 ---------------------------------------------
  logic [3:0]  op, fn, rd, rs1, rs2, sr2_sel;
  logic [31:0] imm, imm_x4;
  logic [31:0] fwr1Out, fwr2Out, sr2Out, aluMuxOut, aluOut;
  logic        memWrite, memtoReg, regWrite, jal, branch, use_imm, cmp_res;

  assign instWord = instMemory.data[pcOut[9:2]];
  assign op       = instWord[OP_LSB  +: 4];
  assign fn       = instWord[FN_LSB  +: 4];
  assign rd       = instWord[RD_LSB  +: 4];
  assign rs1      = instWord[RS1_LSB +: 4];
  assign rs2      = instWord[RS2_LSB +: 4];
  assign imm      = {{16{instWord[15]}}, instWord[15:0]};
  assign imm_x4   = {imm[29:0], 2'b00};
  assign pc_plus4 = pcOut + 32'd4;

  // Stores and branches take their second register from the rd field
  assign sr2_sel  = (op == OP_SW || op == OP_BRANCH) ? rd : rs2;

  // The writeback bypass doubles as the write-before-read register file
  // behaviour, so back-to-back and load-use dependencies never stall.
  assign fwr1Out  = (buff_regWrite && buff_rd == rs1)     ? dataMuxOut : dprf.regs[rs1];
  assign fwr2Out  = (buff_regWrite && buff_rd == sr2_sel) ? dataMuxOut : dprf.regs[sr2_sel];
  assign sr2Out   = fwr2Out;

  assign use_imm   = (op == OP_ALU_I) || (op == OP_CMP_I) || (op == OP_LW) ||
                     (op == OP_SW)    || (op == OP_JAL);
  assign aluMuxOut = use_imm ? imm : fwr2Out;
  assign cmp_res   = cmp_op(fn, fwr1Out, aluMuxOut);

  // Decode control and select the stage-1 result for this opcode
  always_comb begin
    aluOut   = 32'h0;
    memWrite = 1'b0;
    memtoReg = 1'b0;
    regWrite = 1'b0;
    jal      = 1'b0;
    branch   = 1'b0;
    case (op)
      OP_ALU_R, OP_ALU_I: begin
        aluOut   = alu_op(fn, fwr1Out, aluMuxOut);
        regWrite = 1'b1;
      end
      OP_CMP_R, OP_CMP_I: begin
        aluOut   = {31'b0, cmp_res};
        regWrite = 1'b1;
      end
      OP_LW: begin
        aluOut   = fwr1Out + imm;
        memtoReg = 1'b1;
        regWrite = 1'b1;
      end
      OP_SW: begin
        aluOut   = fwr1Out + imm;
        memWrite = 1'b1;
      end
      OP_BRANCH: branch = cmp_res;
      OP_JAL: begin
        aluOut   = pc_plus4;
        jal      = 1'b1;
        regWrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Next PC resolved in the same cycle: no delay slot, nothing to flush
  always_comb begin
    pc_d = pc_plus4;
    if (branch)   pc_d = pc_plus4 + imm_x4;
    else if (jal) pc_d = fwr1Out + imm_x4;
  end

  // PC and stage-2 pipeline buffers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcOut         <= 32'h0;
      buff_aluOut   <= 32'h0;
      buff_sr2Out   <= 32'h0;
      buff_instWord <= 32'h0;
      buff_memWrite <= 1'b0;
      buff_memtoReg <= 1'b0;
      buff_regWrite <= 1'b0;
      buff_jal      <= 1'b0;
      buff_KEY      <= 4'h0;
      buff_SW       <= 10'h0;
    end else begin
      pcOut         <= pc_d;
      buff_aluOut   <= aluOut;
      buff_sr2Out   <= sr2Out;
      buff_instWord <= instWord;
      buff_memWrite <= memWrite;
      buff_memtoReg <= memtoReg;
      buff_regWrite <= regWrite;
      buff_jal      <= jal;
      buff_KEY      <= KEY;
      buff_SW       <= SW;
    end
  end

  // ---------------- stage 2 ---------------------------------------------
  logic [15:0] hex_d, hex_q;
  logic [9:0]  ledr_d, ledr_q;
  logic [7:0]  ledg_d, ledg_q;

  assign buff_rd    = buff_instWord[RD_LSB +: 4];
  assign is_io      = (buff_aluOut[31:28] == IO_REGION);
  assign ram_we     = buff_memWrite && !is_io;
  assign memDataOut = dataMemory.data[buff_aluOut[12:2]];

  // Load source: keys are inverted so a pressed key reads as 1
  always_comb begin
    load_data = memDataOut;
    if (is_io) begin
      case (buff_aluOut)
        IO_KEY:  load_data = {28'b0, ~buff_KEY};
        IO_SW:   load_data = {22'b0, buff_SW};
        default: load_data = 32'h0;
      endcase
    end
  end

  assign dataMuxOut = buff_memtoReg ? load_data : buff_aluOut;

  // Store-mapped output registers
  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    if (buff_memWrite) begin
      case (buff_aluOut)
        IO_HEX:  hex_d  = buff_sr2Out[15:0];
        IO_LEDR: ledr_d = buff_sr2Out[9:0];
        IO_LEDG: ledg_d = buff_sr2Out[7:0];
        default: ;
      endcase
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q  <= 16'h0;
      ledr_q <= 10'h0;
      ledg_q <= 8'h0;
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
    end
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

  seven_seg_decoder u_hex0 (.nibble(hex_q[3:0]),   .seg(HEX0));
  seven_seg_decoder u_hex1 (.nibble(hex_q[7:4]),   .seg(HEX1));
  seven_seg_decoder u_hex2 (.nibble(hex_q[11:8]),  .seg(HEX2));
  seven_seg_decoder u_hex3 (.nibble(hex_q[15:12]), .seg(HEX3));

  // Board clock pin and buffer bits that no logic consumes
  logic unused_ok;
  assign unused_ok = ^{CLOCK_50, buff_jal, buff_instWord[31:24], buff_instWord[19:0]};

endmodule
`default_nettype wire

// File: tb/tb_project_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_project_2
// Purpose  : Directed program for project_2; expected writebacks and fetch
//            PCs are queued up front and popped as the pipeline retires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_project_2;

  logic       clk = 1'b0;
  logic       reset;
  logic       CLOCK_50 = 1'b0;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic [7:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  project_2 dut (
    .clk(clk), .reset(reset), .CLOCK_50(CLOCK_50), .SW(SW), .KEY(KEY),
    .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5  clk = ~clk;
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] fn,
                                      input logic [3:0] rd, input logic [3:0] rs1,
                                      input logic [15:0] lo);
    return {op, fn, rd, rs1, lo};
  endfunction

  logic [31:0] prog [32];
  logic [35:0] wb_q [$];   // {rd, value}
  logic [31:0] pc_q [$];
  bit          chk_en = 1'b0;
  int          wb_idx = 0;

  // Retirement monitor, sampled mid-cycle
  always @(negedge clk) begin
    logic [35:0] e;
    if (chk_en) begin
      if (pc_q.size() > 0) check("pc", dut.pcOut, pc_q.pop_front());
      if (dut.buff_regWrite) begin
        if (wb_q.size() == 0) begin
          check("wb_extra_rd", {28'b0, dut.buff_instWord[23:20]}, 32'hDEAD_BEEF);
        end else begin
          e = wb_q.pop_front();
          check($sformatf("wb%0d_rd", wb_idx), {28'b0, dut.buff_instWord[23:20]}, {28'b0, e[35:32]});
          check($sformatf("wb%0d_val", wb_idx), dut.dataMuxOut, e[31:0]);
          wb_idx++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) prog[i] = 32'hF000_0000;  // op F = NOP
    prog[0]  = enc(4'h0, 4'h0, 4'd3,  4'd1,  16'h2000);    // ADD  r3,r1,r2
    prog[1]  = enc(4'h0, 4'h0, 4'd4,  4'd3,  16'h1000);    // ADD  r4,r3,r1
    prog[2]  = enc(4'h5, 4'h0, 4'd3,  4'd0,  16'h0100);    // SW   r3,0x100(r0)
    prog[3]  = enc(4'h9, 4'h0, 4'd5,  4'd0,  16'h0100);    // LW   r5,0x100(r0)
    prog[4]  = enc(4'h6, 4'h1, 4'd1,  4'd1,  16'h0002);    // BEQ  r1,r1,+2
    prog[5]  = enc(4'h8, 4'h0, 4'd7,  4'd0,  16'h0007);    // skipped
    prog[6]  = enc(4'h8, 4'h0, 4'd8,  4'd0,  16'h0008);    // skipped
    prog[7]  = enc(4'h8, 4'h0, 4'd6,  4'd0,  16'h0155);    // ADDI r6,r0,0x155
    prog[8]  = enc(4'h5, 4'h0, 4'd6,  4'd9,  16'h0004);    // SW   r6 -> LEDR
    prog[9]  = enc(4'h9, 4'h0, 4'd10, 4'd9,  16'h0014);    // LW   r10 <- SW
    prog[10] = enc(4'h5, 4'h0, 4'd1,  4'd9,  16'h0000);    // SW   r1 -> HEX
    prog[11] = enc(4'h5, 4'h0, 4'd2,  4'd9,  16'h0008);    // SW   r2 -> LEDG
    prog[12] = enc(4'h9, 4'h0, 4'd11, 4'd9,  16'h0010);    // LW   r11 <- ~KEY
    prog[13] = enc(4'hA, 4'h2, 4'd12, 4'd1,  16'd25);      // CMPI LT r12,r1,25
    prog[14] = enc(4'h0, 4'h1, 4'd13, 4'd1,  16'h2000);    // SUB  r13,r1,r2
    prog[15] = enc(4'h2, 4'hB, 4'd14, 4'd13, 16'h1000);    // CMP  GT r14,r13,r1
    prog[16] = enc(4'h0, 4'h6, 4'd15, 4'd1,  16'h2000);    // XOR  r15,r1,r2
    prog[17] = enc(4'hB, 4'h0, 4'd7,  4'd0,  16'd20);      // JAL  r7,r0,20
    prog[18] = enc(4'h8, 4'h0, 4'd8,  4'd0,  16'h0008);    // skipped
    prog[19] = enc(4'h8, 4'h0, 4'd8,  4'd0,  16'h0009);    // skipped
    prog[20] = enc(4'h0, 4'hD, 4'd8,  4'd1,  16'h2000);    // NOR  r8,r1,r2
    prog[21] = enc(4'h6, 4'h9, 4'd1,  4'd1,  16'h0003);    // BNE  r1,r1 (not taken)
    prog[22] = enc(4'h6, 4'h1, 4'd0,  4'd0,  16'hFFFF);    // BEQ  r0,r0,-1 (spin)

    // Backdoor preload before the first clock edge
    for (int i = 0; i < 256; i++)  dut.instMemory.data[i] <= (i < 32) ? prog[i] : 32'hF000_0000;
    for (int i = 0; i < 2048; i++) dut.dataMemory.data[i] <= 32'h0;
    for (int i = 0; i < 16; i++)
      dut.dprf.regs[i] <= (i == 1) ? 32'd10 : (i == 2) ? 32'd20 :
                          (i == 9) ? 32'hF000_0000 : 32'h0;

    reset = 1'b0;
    SW    = 10'h2A5;
    KEY   = 4'b1010;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pc",   dut.pcOut, 32'h0);
    check("rst_ledr", LEDR, 32'h0);
    check("rst_ledg", LEDG, 32'h0);
    check("rst_hex0", HEX0, 32'h40);
    check("rst_hex3", HEX3, 32'h40);
    check("rst_regw", dut.buff_regWrite, 32'h0);
    check("rst_memw", dut.buff_memWrite, 32'h0);

    wb_q = '{{4'd3, 32'd30}, {4'd4, 32'd40}, {4'd5, 32'd30}, {4'd6, 32'h155},
             {4'd10, 32'h2A5}, {4'd11, 32'd5}, {4'd12, 32'd1}, {4'd13, 32'hFFFF_FFF6},
             {4'd14, 32'd0}, {4'd15, 32'd30}, {4'd7, 32'd72}, {4'd8, 32'hFFFF_FFE1}};
    pc_q = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd28, 32'd32, 32'd36, 32'd40, 32'd44,
             32'd48, 32'd52, 32'd56, 32'd60, 32'd64, 32'd68, 32'd80, 32'd84,
             32'd88, 32'd88, 32'd88};

    reset = 1'b1;
    #1 chk_en = 1'b1;

    for (int c = 0; c < 100 && (pc_q.size() > 0 || wb_q.size() > 0); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pc_q_left", pc_q.size(), 32'd0);
    check("wb_q_left", wb_q.size(), 32'd0);

    // Architectural state after the program
    check("dmem64",   dut.dataMemory.data[64], 32'd30);
    check("dmem0_io", dut.dataMemory.data[0],  32'd0);
    check("dmem1_io", dut.dataMemory.data[1],  32'd0);
    check("dmem2_io", dut.dataMemory.data[2],  32'd0);
    check("ledr",     LEDR, 32'h155);
    check("ledg",     LEDG, 32'h14);
    check("hex0",     HEX0, 32'h08);
    check("hex1",     HEX1, 32'h40);
    check("hex3",     HEX3, 32'h40);
    check("r3",       dut.dprf.regs[3], 32'd30);
    check("r5",       dut.dprf.regs[5], 32'd30);
    check("r7",       dut.dprf.regs[7], 32'd72);
    check("r8",       dut.dprf.regs[8], 32'hFFFF_FFE1);

    // Asynchronous reset in the middle of the spin loop
    chk_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_pc",   dut.pcOut, 32'h0);
    check("mid_ledr", LEDR, 32'h0);
    check("mid_ledg", LEDG, 32'h0);
    check("mid_hex0", HEX0, 32'h40);
    check("mid_r1",   dut.dprf.regs[1], 32'd10);
    check("mid_r2",   dut.dprf.regs[2], 32'd20);
    check("mid_r3",   dut.dprf.regs[3], 32'd30);
    check("mid_dmem", dut.dataMemory.data[64], 32'd30);

    // First fetch after release comes from address 0
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rel_pc",   dut.pcOut, 32'd4);
    check("rel_inst", dut.buff_instWord, prog[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
